// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data-memory responder for an RV32I core.
// Serves RAM loads/stores with byte/half/word granularity, a PWM duty register
// and two free-running timers (millis, micros) mapped at the top of the address space.
//
// Ports:
//   clk, reset           - single clock, asynchronous active-high reset
//   dmem_req             - request valid this cycle (accepted every edge, no back-pressure)
//   dmem_wren            - 1 = store, 0 = load
//   funct3               - RV32I load/store width code
//   dmem_address         - byte address
//   dmem_data_in         - store data, right-aligned
//   dmem_data_out        - load result, extended to 32 bits, held until the next ack
//   dmem_ack             - one-cycle response strobe, the cycle after acceptance
//   dmem_err             - error qualifier, only ever high together with dmem_ack
//   led, red, green, blue - active-high PWM outputs
module dmem_responder #(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter logic [31:0] RAM_BASE  = 32'h0000_2000,
  parameter int unsigned RAM_WORDS = 2048,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_req,
  input  logic        dmem_wren,
  input  logic [2:0]  funct3,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        dmem_ack,
  output logic        dmem_err,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned MS_DIV    = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned US_DIV    = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
  localparam logic [31:0] MS_LAST   = 32'(MS_DIV - 1);
  localparam logic [31:0] US_LAST   = 32'(US_DIV - 1);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

  logic [31:0] r_mem [RAM_WORDS];

  logic [31:0] r_data;
  logic        r_ack, r_err;
  logic [31:0] r_duty, r_millis, r_micros, r_ms_pre, r_us_pre;
  logic [7:0]  r_pwm_cnt;
  logic        r_led, r_red, r_green, r_blue;

  logic [31:0] w_off;
  logic [AW-1:0] w_idx;
  logic        w_ram_hit, w_duty_hit, w_ms_hit, w_us_hit, w_mapped;
  logic        w_accept, w_f3_ok, w_misalign, w_err, w_we;
  logic [1:0]  w_size;
  logic [31:0] w_rword, w_load, w_wdata, w_merged;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be;

  // Requests seen while reset is high must not touch RAM or the response path.
  assign w_accept = dmem_req & ~reset;

  // Subtracting the base makes addresses below RAM_BASE wrap high and miss the range test.
  assign w_off      = dmem_address - RAM_BASE;
  assign w_idx      = w_off[AW+1:2];
  assign w_ram_hit  = (w_off < RAM_BYTES);
  assign w_duty_hit = (dmem_address[31:2] == 30'h3FFF_FFFF);
  assign w_ms_hit   = (dmem_address[31:2] == 30'h3FFF_FFFE);
  assign w_us_hit   = (dmem_address[31:2] == 30'h3FFF_FFFD);
  assign w_mapped   = w_ram_hit | w_duty_hit | w_ms_hit | w_us_hit;

  always_comb begin
    w_size  = 2'd0;
    w_f3_ok = 1'b0;
    case (funct3)
      3'b000:         begin w_size = 2'd0; w_f3_ok = 1'b1;       end
      3'b001:         begin w_size = 2'd1; w_f3_ok = 1'b1;       end
      3'b010:         begin w_size = 2'd2; w_f3_ok = 1'b1;       end
      3'b100:         begin w_size = 2'd0; w_f3_ok = ~dmem_wren; end
      3'b101:         begin w_size = 2'd1; w_f3_ok = ~dmem_wren; end
      default:        begin w_size = 2'd0; w_f3_ok = 1'b0;       end
    endcase
  end

  assign w_misalign = ((w_size == 2'd1) & dmem_address[0]) |
                      ((w_size == 2'd2) & (dmem_address[1:0] != 2'b00));
  assign w_err      = ~w_f3_ok | w_misalign | ~w_mapped;
  assign w_we       = w_accept & dmem_wren & ~w_err;

  always_comb begin
    w_rword = '0;
    if (w_ram_hit)       w_rword = r_mem[w_idx];
    else if (w_duty_hit) w_rword = r_duty;
    else if (w_ms_hit)   w_rword = r_millis;
    else if (w_us_hit)   w_rword = r_micros;
  end

  assign w_byte = w_rword[8*dmem_address[1:0] +: 8];
  assign w_half = dmem_address[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load = '0;
    case (funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_rword;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = '0;
    endcase
  end

  // Store data is replicated across lanes; byte enables pick the lane(s) that change.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = dmem_data_in;
    case (w_size)
      2'd0: begin
        w_be    = 4'b0001 << dmem_address[1:0];
        w_wdata = {4{dmem_data_in[7:0]}};
      end
      2'd1: begin
        w_be    = dmem_address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{dmem_data_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = dmem_data_in;
      end
    endcase
    w_merged = w_rword;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_merged[8*i +: 8] = w_wdata[8*i +: 8];
    end
  end

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_we && w_ram_hit) r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_data    <= '0;
      r_duty    <= '0;
      r_pwm_cnt <= '0;
      r_led     <= 1'b0;
      r_red     <= 1'b0;
      r_green   <= 1'b0;
      r_blue    <= 1'b0;
      r_millis  <= '0;
      r_micros  <= '0;
      r_ms_pre  <= '0;
      r_us_pre  <= '0;
    end else begin
      r_ack <= w_accept;
      r_err <= w_accept & w_err;
      if (w_accept) r_data <= (w_err | dmem_wren) ? 32'd0 : w_load;

      if (w_we && w_duty_hit) r_duty <= w_merged;

      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_led     <= (r_pwm_cnt < r_duty[7:0]);
      r_red     <= (r_pwm_cnt < r_duty[15:8]);
      r_green   <= (r_pwm_cnt < r_duty[23:16]);
      r_blue    <= (r_pwm_cnt < r_duty[31:24]);

      // A load sampling the timer on the same edge it increments sees the old value.
      if (r_ms_pre == MS_LAST) begin
        r_ms_pre <= '0;
        r_millis <= r_millis + 32'd1;
      end else begin
        r_ms_pre <= r_ms_pre + 32'd1;
      end
      if (r_us_pre == US_LAST) begin
        r_us_pre <= '0;
        r_micros <= r_micros + 32'd1;
      end else begin
        r_us_pre <= r_us_pre + 32'd1;
      end
    end
  end

  assign dmem_data_out = r_data;
  assign dmem_ack      = r_ack;
  assign dmem_err      = r_err;
  assign led           = r_led;
  assign red           = r_red;
  assign green         = r_green;
  assign blue          = r_blue;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wren;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic [31:0] dout;
  logic        ack, err, led, red, green, blue;

  int checks = 0;
  int failures = 0;
  int unsigned cyc;

  always #5 clk = ~clk;

  dmem_responder #(.CLK_HZ(2000000)) u_dut (
    .clk          (clk),
    .reset        (rst),
    .dmem_req     (req),
    .dmem_wren    (wren),
    .funct3       (f3),
    .dmem_address (addr),
    .dmem_data_in (wdata),
    .dmem_data_out(dout),
    .dmem_ack     (ack),
    .dmem_err     (err),
    .led          (led),
    .red          (red),
    .green        (green),
    .blue         (blue)
  );

  // Rising edges seen since reset was last released.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Reference model: byte-addressed RAM and duty register, timers derived from elapsed cycles.
  logic [7:0] m_ram [8192];
  logic [7:0] m_duty [4];

  function automatic void model_access(input logic w, input logic [2:0] f,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] rd, output logic e);
    int n = 1;
    bit sgn = 0;
    bit ok = 1;
    int region = -1;
    logic [31:0] tv = 0;
    logic [31:0] val = 0;
    logic [7:0] b;
    case (f)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: begin n = 4; end
      3'd4: begin n = 1; ok = !w; end
      3'd5: begin n = 2; ok = !w; end
      default: ok = 0;
    endcase
    if (a >= 32'hFFFF_FFFC) region = 1;
    else if (a >= 32'hFFFF_FFF8) begin region = 2; tv = cyc / 2000; end
    else if (a >= 32'hFFFF_FFF4) begin region = 3; tv = cyc / 2; end
    else if (a >= 32'h2000 && a < 32'h4000) region = 0;
    e = !ok || region < 0 || (a % n) != 0;
    rd = 0;
    if (e) return;
    for (int i = 0; i < n; i++) begin
      if (w) begin
        if (region == 0) m_ram[a - 32'h2000 + i] = d[8*i +: 8];
        else if (region == 1) m_duty[a[1:0] + i] = d[8*i +: 8];
      end else begin
        if (region == 0) b = m_ram[a - 32'h2000 + i];
        else if (region == 1) b = m_duty[a[1:0] + i];
        else b = 8'(tv >> (8 * (a[1:0] + i)));
        val = val | (32'(b) << (8 * i));
      end
    end
    if (!w && sgn && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 1);
    if (!w) rd = val;
  endfunction

  // Drives one request at the current negedge and samples the response at the next one.
  task automatic txn(input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] exp_d, output logic exp_e,
                     output logic [31:0] got_d, output logic got_e, output logic got_ack);
    model_access(w, f, a, d, exp_d, exp_e);
    req = 1; wren = w; f3 = f; addr = a; wdata = d;
    @(negedge clk);
    got_d = dout; got_e = err; got_ack = ack;
    req = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = 0; wren = 0; f3 = 0; addr = 0; wdata = 0;
    for (int i = 0; i < 4; i++) m_duty[i] = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack, err, dout, led, red, green, blue} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b err=%b dout=%h pwm=%b%b%b%b, want all 0",
               ack, err, dout, led, red, green, blue);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_noack: ack=%b err=%b, want 0 0", ack, err);
    end
  endtask

  task automatic init_ram();
    logic [31:0] ed, gd; logic ee, ge, ga;
    for (int i = 0; i < 16; i++) txn(1, 3'd2, 32'h2000 + 4 * i, 0, ed, ee, gd, ge, ga);
    for (int i = 0; i < 4; i++) txn(1, 3'd2, 32'h3FF0 + 4 * i, 0, ed, ee, gd, ge, ga);
  endtask

  task automatic test_word();
    logic [31:0] ed, gd; logic ee, ge, ga;
    txn(1, 3'd2, 32'h2000, 32'hDEADBEEF, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0) begin
      failures++;
      $display("FAIL sw_ack: ack=%b err=%b, want 1 0", ga, ge);
    end
    txn(0, 3'd2, 32'h2000, 0, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0 || gd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw_after_sw: ack=%b err=%b data=%h, want 1 0 deadbeef", ga, ge, gd);
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || dout !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL ack_one_cycle_hold: ack=%b err=%b data=%h, want 0 0 deadbeef",
               ack, err, dout);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] ed, gd; logic ee, ge, ga;
    logic [2:0]  f3s  [4] = '{3'd2, 3'd0, 3'd4, 3'd1};
    logic [31:0] as   [4] = '{32'h2000, 32'h2003, 32'h2003, 32'h2002};
    logic [31:0] want [4] = '{32'h80000000, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8000};
    txn(1, 3'd2, 32'h2000, 0, ed, ee, gd, ge, ga);
    txn(1, 3'd0, 32'h2003, 32'h80, ed, ee, gd, ge, ga);
    for (int i = 0; i < 4; i++) begin
      txn(0, f3s[i], as[i], 0, ed, ee, gd, ge, ga);
      checks++;
      if (ga !== 1'b1 || ge !== 1'b0 || gd !== want[i]) begin
        failures++;
        $display("FAIL lane_%0d: ack=%b err=%b data=%h, want 1 0 %h", i, ga, ge, gd, want[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] ed, gd; logic ee, ge, ga;
    logic        ws  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  fs  [6] = '{3'd2, 3'd1, 3'd2, 3'd5, 3'd3, 3'd4};
    logic [31:0] as  [6] = '{32'h2002, 32'h2001, 32'h1000, 32'h2001, 32'h2000, 32'h2000};
    for (int i = 0; i < 6; i++) begin
      txn(ws[i], fs[i], as[i], 32'h5555AAAA, ed, ee, gd, ge, ga);
      checks++;
      if (ga !== 1'b1 || ge !== 1'b1 || gd !== 32'd0) begin
        failures++;
        $display("FAIL err_case_%0d: ack=%b err=%b data=%h, want 1 1 0", i, ga, ge, gd);
      end
    end
    txn(0, 3'd2, 32'h2000, 0, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0 || gd !== 32'h80000000) begin
      failures++;
      $display("FAIL err_no_change: ack=%b err=%b data=%h, want 1 0 80000000", ga, ge, gd);
    end
  endtask

  task automatic test_pwm();
    logic [31:0] ed, gd; logic ee, ge, ga;
    int n_led = 0, n_red = 0, n_green = 0, n_blue = 0;
    txn(1, 3'd2, 32'hFFFF_FFFC, 32'h00FF8000, ed, ee, gd, ge, ga);
    txn(0, 3'd4, 32'hFFFF_FFFD, 0, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0 || gd !== 32'h80) begin
      failures++;
      $display("FAIL duty_readback: ack=%b err=%b data=%h, want 1 0 80", ga, ge, gd);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      n_led += int'(led); n_red += int'(red); n_green += int'(green); n_blue += int'(blue);
      @(negedge clk);
    end
    checks++;
    if (n_led != 0 || n_red != 128 || n_green != 255 || n_blue != 0) begin
      failures++;
      $display("FAIL pwm_counts: led=%0d red=%0d green=%0d blue=%0d, want 0 128 255 0",
               n_led, n_red, n_green, n_blue);
    end
  endtask

  task automatic test_timers();
    logic [31:0] ed, gd; logic ee, ge, ga;
    int guard = 0;
    rst = 1;
    for (int i = 0; i < 4; i++) m_duty[i] = 0;
    @(negedge clk);
    rst = 0;
    while (cyc != 2000 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc != 2000) begin
      failures++;
      $display("FAIL timer_wait: cyc=%0d, want 2000", cyc);
    end
    txn(0, 3'd2, 32'hFFFF_FFF8, 0, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0 || gd !== 32'd1) begin
      failures++;
      $display("FAIL millis_2000: ack=%b err=%b data=%0d, want 1 0 1", ga, ge, gd);
    end
    txn(0, 3'd2, 32'hFFFF_FFF4, 0, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0 || gd !== 32'd1000) begin
      failures++;
      $display("FAIL micros_2001: ack=%b err=%b data=%0d, want 1 0 1000", ga, ge, gd);
    end
    txn(1, 3'd2, 32'hFFFF_FFF8, 32'h1234, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0) begin
      failures++;
      $display("FAIL timer_store_drop: ack=%b err=%b, want 1 0", ga, ge);
    end
    txn(0, 3'd2, 32'hFFFF_FFF8, 0, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0 || gd !== 32'd1) begin
      failures++;
      $display("FAIL millis_after_store: ack=%b err=%b data=%0d, want 1 0 1", ga, ge, gd);
    end
    txn(0, 3'd5, 32'hFFFF_FFF4, 0, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== ee || gd !== ed) begin
      failures++;
      $display("FAIL micros_lhu: ack=%b err=%b data=%h, want 1 %b %h", ga, ge, gd, ee, ed);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q_d [$];
    logic        q_e [$];
    logic [31:0] ed, a, d;
    logic        ee, w;
    logic [2:0]  f;
    for (int i = 0; i <= 300; i++) begin
      if (i > 0) begin
        checks++;
        if (ack !== 1'b1 || err !== q_e[0] || dout !== q_d[0]) begin
          failures++;
          $display("FAIL b2b_%0d: ack=%b err=%b data=%h, want 1 %b %h",
                   i - 1, ack, err, dout, q_e[0], q_d[0]);
        end
        void'(q_d.pop_front());
        void'(q_e.pop_front());
      end
      if (i == 300) begin
        req = 0;
        break;
      end
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      d = $urandom;
      case ($urandom_range(0, 7))
        0, 1, 2: a = 32'h2000 + $urandom_range(0, 63);
        3:       a = 32'h3FF0 + $urandom_range(0, 15);
        4:       a = 32'hFFFF_FFFC + $urandom_range(0, 3);
        5:       a = 32'hFFFF_FFF4 + $urandom_range(0, 7);
        6:       a = 32'h1FFC + $urandom_range(0, 3);
        default: a = 32'h4000 + $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 3) != 0) a[1:0] = (f[1:0] == 2'd2) ? 2'd0 : {a[1], 1'b0};
      model_access(w, f, a, d, ed, ee);
      q_d.push_back(ed);
      q_e.push_back(ee);
      req = 1; wren = w; f3 = f; addr = a; wdata = d;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed, gd; logic ee, ge, ga;
    txn(1, 3'd2, 32'hFFFF_FFFC, 32'hFFFFFFFF, ed, ee, gd, ge, ga);
    txn(1, 3'd2, 32'h2004, 32'hCAFEF00D, ed, ee, gd, ge, ga);
    req = 1; wren = 0; f3 = 3'd2; addr = 32'h2004;
    @(posedge clk);
    #1;
    rst = 1;
    req = 0;
    for (int i = 0; i < 4; i++) m_duty[i] = 0;
    #1;
    checks++;
    if ({ack, err, dout, led, red, green, blue} !== 38'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: ack=%b err=%b dout=%h pwm=%b%b%b%b, want all 0",
               ack, err, dout, led, red, green, blue);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || dout !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_noack: ack=%b err=%b data=%h, want 0 0 0", ack, err, dout);
    end
    txn(0, 3'd2, 32'h2004, 0, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0 || gd !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL ram_after_reset: ack=%b err=%b data=%h, want 1 0 cafef00d", ga, ge, gd);
    end
    txn(0, 3'd2, 32'hFFFF_FFFC, 0, ed, ee, gd, ge, ga);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0 || gd !== 32'd0) begin
      failures++;
      $display("FAIL duty_after_reset: ack=%b err=%b data=%h, want 1 0 0", ga, ge, gd);
    end
  endtask

  initial begin
    test_reset();
    init_ram();
    test_word();
    test_lanes();
    test_errors();
    test_pwm();
    test_timers();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
